// File: rtl/divider_sequential_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and default operand widths.
package divider_sequential_pkg;

    localparam int DEFAULT_DIVIDEND_WIDTH = 4;
    localparam int DEFAULT_DIVISOR_WIDTH  = 2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_sequential_subtractor.sv
// Ripple subtractor built from 1-bit full-adder cells: a - b = a + ~b + 1.
// o_borrow is high when the result would be negative.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_carry;
    assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));
endmodule

module subtractor_nbit #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_bInv;

    assign w_carry[0] = 1'b1;
    assign w_bInv     = ~i_b;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        full_adder_cell u_cell (
            .i_a     (i_a[g]),
            .i_b     (w_bInv[g]),
            .i_carry (w_carry[g]),
            .o_sum   (o_diff[g]),
            .o_carry (w_carry[g+1])
        );
    end

    // No carry out of the top cell means the subtraction borrowed.
    assign o_borrow = ~w_carry[WIDTH];
endmodule

// File: rtl/divider_sequential.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: DIVIDER_DIV_BY_ZERO_EN (detect divisor 0 at start).
module divider_sequential
    import divider_sequential_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEFAULT_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEFAULT_DIVISOR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);
    localparam int CNT_W = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_WIDTH - 1);

    div_state_t                r_state;
    div_state_t                w_nextState;
    logic [DIVIDEND_WIDTH-1:0] r_shift;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic [DIVISOR_WIDTH-1:0]  r_partRem;
    logic [CNT_W-1:0]          r_count;
    logic [DIVIDEND_WIDTH-1:0] r_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_remainder;

    logic [DIVISOR_WIDTH:0]    w_trial;
    logic [DIVISOR_WIDTH:0]    w_diff;
    logic                      w_borrow;
    logic [DIVISOR_WIDTH-1:0]  w_nextRem;
    logic [DIVIDEND_WIDTH-1:0] w_nextShift;
    logic                      w_lastStep;
    logic                      w_startZero;
    logic                      w_unusedDiffMsb;

    // r_shift drains dividend bits from the MSB while quotient bits enter at the LSB.
    assign w_trial     = {r_partRem, r_shift[DIVIDEND_WIDTH-1]};
    assign w_nextRem   = w_borrow ? w_trial[DIVISOR_WIDTH-1:0] : w_diff[DIVISOR_WIDTH-1:0];
    assign w_nextShift = {r_shift[DIVIDEND_WIDTH-2:0], ~w_borrow};
    assign w_lastStep  = (r_count == LAST_STEP);
    assign w_unusedDiffMsb = w_diff[DIVISOR_WIDTH];

    subtractor_nbit #(.WIDTH(DIVISOR_WIDTH + 1)) u_trialSub (
        .i_a      (w_trial),
        .i_b      ({1'b0, r_divisor}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

`ifdef DIVIDER_DIV_BY_ZERO_EN
    logic r_divByZero;
    assign w_startZero = (divisor == '0);
    assign div_by_zero = r_divByZero;
`else
    assign w_startZero = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) r_state <= DIV_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            DIV_IDLE: if (start) w_nextState = w_startZero ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (w_lastStep) w_nextState = DIV_DONE;
            DIV_DONE: w_nextState = DIV_IDLE;
            default:  w_nextState = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != DIV_IDLE);
        done = (r_state == DIV_DONE);
    end

    // Result registers load only on the transition into DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift     <= '0;
            r_divisor   <= '0;
            r_partRem   <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIVIDER_DIV_BY_ZERO_EN
            r_divByZero <= 1'b0;
`endif
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_partRem <= '0;
                        r_count   <= '0;
`ifdef DIVIDER_DIV_BY_ZERO_EN
                        if (w_startZero) begin
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_divByZero <= 1'b1;
                        end
`endif
                    end
                end
                DIV_CALC: begin
                    r_shift   <= w_nextShift;
                    r_partRem <= w_nextRem;
                    r_count   <= r_count + CNT_W'(1);
                    if (w_lastStep) begin
                        r_quotient  <= w_nextShift;
                        r_remainder <= w_nextRem;
`ifdef DIVIDER_DIV_BY_ZERO_EN
                        r_divByZero <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
endmodule

// File: tb/tb_divider_sequential.sv
// Self-checking bench for divider_sequential at default widths (4/2).
module tb_divider_sequential;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] dvd;
        logic [1:0] dvs;
        logic [3:0] q;
        logic [1:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    divider_sequential dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Lat counts edges after the accepting edge until done is seen; -1 on timeout.
    task automatic applyStimulus(input logic [3:0] dvd, input logic [1:0] dvs,
                                 output logic [3:0] q, output logic [1:0] r,
                                 output logic dbz, output int lat, output logic busyAfter);
        @(negedge clock);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clock);
        #1;
        start     = 1'b0;
        busyAfter = busy;
        lat = -1;
        q   = 'x;
        r   = 'x;
        dbz = 'x;
        for (int e = 0; e <= 20; e++) begin
            if (e > 0) begin
                @(posedge clock);
                #1;
            end
            if (done) begin
                lat = e;
                q   = quotient;
                r   = remainder;
                dbz = div_by_zero;
                break;
            end
        end
    endtask

    task automatic checkPulseEnds(input string name);
        @(posedge clock);
        #1;
        checkOutput({name, " done falls"}, done, 0);
        checkOutput({name, " busy falls"}, busy, 0);
    endtask

    initial begin
        logic [3:0] q;
        logic [1:0] r;
        logic       dbz;
        int         lat;
        logic       busyAfter;
        int         doneCount;

        vecs[0] = '{"9/2",  4'd9,  2'd2, 4'd4,  2'd1, 1'b0, 4};
        vecs[1] = '{"15/1", 4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 4};
        vecs[2] = '{"6/3",  4'd6,  2'd3, 4'd2,  2'd0, 1'b0, 4};
        vecs[3] = '{"14/3", 4'd14, 2'd3, 4'd4,  2'd2, 1'b0, 4};
        vecs[4] = '{"7/2",  4'd7,  2'd2, 4'd3,  2'd1, 1'b0, 4};
        vecs[5] = '{"15/3", 4'd15, 2'd3, 4'd5,  2'd0, 1'b0, 4};
        vecs[6] = '{"2/3",  4'd2,  2'd3, 4'd0,  2'd2, 1'b0, 4};
`ifdef DIVIDER_DIV_BY_ZERO_EN
        vecs[7] = '{"13/0", 4'd13, 2'd0, 4'd15, 2'd0, 1'b1, 0};
`else
        vecs[7] = '{"13/0", 4'd13, 2'd0, 4'd15, 2'd1, 1'b0, 4};
`endif
        vecs[8] = '{"0/1",  4'd0,  2'd1, 4'd0,  2'd0, 1'b0, 4};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset quotient", quotient, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset div_by_zero", div_by_zero, 0);
        reset = 1'b0;

        // Each vector starts the cycle after the previous done falls.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, q, r, dbz, lat, busyAfter);
            checkOutput({vecs[i].name, " busy"}, busyAfter, 1);
            checkOutput({vecs[i].name, " latency"}, lat, vecs[i].lat);
            checkOutput({vecs[i].name, " quotient"}, q, vecs[i].q);
            checkOutput({vecs[i].name, " remainder"}, r, vecs[i].r);
            checkOutput({vecs[i].name, " div_by_zero"}, dbz, vecs[i].dbz);
            checkPulseEnds(vecs[i].name);
        end

        // start held during CALC with other operands must not disturb 9/2.
        @(negedge clock);
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 2'd2;
        @(posedge clock);
        #1;
        dividend  = 4'd15;
        divisor   = 2'd1;
        doneCount = 0;
        q = 'x;
        r = 'x;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                doneCount++;
                q = quotient;
                r = remainder;
            end
            if (k < 4) begin
                dividend = 4'(k * 5);
                divisor  = 2'(k);
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("start-while-busy done count", doneCount, 1);
        checkOutput("start-while-busy quotient", q, 4);
        checkOutput("start-while-busy remainder", r, 1);

        // Reset sampled on the second CALC edge.
        @(negedge clock);
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 2'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("mid-reset busy", busy, 0);
        checkOutput("mid-reset done", done, 0);
        checkOutput("mid-reset quotient", quotient, 0);
        checkOutput("mid-reset remainder", remainder, 0);
        checkOutput("mid-reset div_by_zero", div_by_zero, 0);
        applyStimulus(4'd0, 2'd3, q, r, dbz, lat, busyAfter);
        checkOutput("0/3 latency", lat, 4);
        checkOutput("0/3 quotient", q, 0);
        checkOutput("0/3 remainder", r, 0);
        checkPulseEnds("0/3");

        // Sweep: quotient*divisor + remainder must rebuild the dividend.
        for (int d = 0; d < 16; d++) begin
            for (int s = 1; s < 4; s++) begin
                applyStimulus(4'(d), 2'(s), q, r, dbz, lat, busyAfter);
                checkOutput("sweep identity", 32'(q) * 32'(s) + 32'(r), 32'(d));
                checkOutput("sweep remainder bound", {31'd0, (32'(r) < 32'(s))}, 1);
                @(posedge clock);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
